axi_line_master: RTL and testbench
==================================

Name: axi_line_master

Overview:
- Converts single-line cache refill and writeback requests from the SoC data cache into AXI4 INCR bursts on the SoC dbus master port.
- The dbus master port feeds the SoC-side slave of the SoC-to-SDRAM AXI clock-domain crossing.
- Sits directly upstream of that CDC in the core clock domain.
- Handles one outstanding transaction at a time, read or write.

Parameters:
- LINE_WORDS, 8, 32-bit words per cache line; power of two, 2..16.
- ADDR_WIDTH, 32, byte address width.

Ports:
- clk  in  1  core clock
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  1  line request valid
- req_ready  out  1  block idle, accepts request
- req_write  in  1  1 = writeback, 0 = refill
- req_addr  in  ADDR_WIDTH  any byte address inside the line
- wd_valid  in  1  writeback word valid
- wd_ready  out  1  writeback word accepted
- wd_data  in  32  writeback word, ascending address order
- rd_valid  out  1  refill word valid (no backpressure)
- rd_data  out  32  refill word
- rd_last  out  1  final refill word
- done  out  1  one-cycle pulse at transaction end
- err  out  1  qualifies done; any non-OKAY response or burst length mismatch
- m_axi_aw*  out  awaddr ADDR_WIDTH, awlen 8, awsize 3, awburst 2, awvalid 1; awready in
- m_axi_w*  out  wdata 32, wstrb 4, wlast 1, wvalid 1; wready in
- m_axi_b*  bresp 2 in, bvalid 1 in, bready 1 out
- m_axi_ar*  out  araddr ADDR_WIDTH, arlen 8, arsize 3, arburst 2, arvalid 1; arready in
- m_axi_r*  rdata 32 in, rresp 2 in, rlast 1 in, rvalid 1 in, rready 1 out

Behaviour:
- Reset values: all valid/ready/done/err/rd_* outputs 0; state IDLE; counters 0.
- Reset is asynchronous; assertion mid-burst abandons the transaction with no completion pulse. The downstream CDC is reset together with this block.
- Address: line-aligned, i.e. req_addr with low log2(LINE_WORDS*4) bits forced to 0.
- Burst fields: len = LINE_WORDS-1; size = 3'b010; burst = 2'b01 (INCR); wstrb = 4'hF.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR, WR_RESP, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid, latch addr/write; go to WR if write, else RD_ADDR.
- RD_ADDR:
  - arvalid = 1 and held stable until arready.
  - Then go to RD_DATA.
- RD_DATA:
  - rready = 1 constantly.
  - Each beat: rd_valid = rvalid, rd_data = rdata combinationally passed; rd_last asserted on beat LINE_WORDS-1.
  - Beat counter increments per beat.
  - err_acc |= (rresp != 0).
  - err_acc |= 1 if rlast disagrees with counter == LINE_WORDS-1.
  - After beat LINE_WORDS-1, go to DONE.
- WR:
  - awvalid and wvalid are independent.
  - awvalid = 1 until AW handshake (aw_done flag).
  - wvalid = wd_valid and wd_ready = wready while beats remain; wdata = wd_data; wlast = (wcount == LINE_WORDS-1).
  - W beats may precede, coincide with or follow the AW handshake.
  - Go to WR_RESP when aw_done and the last W beat are both complete; the same-cycle completion of both is legal.
- WR_RESP:
  - bready = 1.
  - On bvalid, err_acc |= (bresp != 0); go to DONE.
- DONE:
  - done = 1 for one cycle; err = err_acc.
  - Clear counters and err_acc; return to IDLE. req_ready returns to 1 the next cycle.
- Throughput: a new request is accepted no earlier than 1 cycle after done.
- Latency: a refill with AXI ready always high gives arvalid 1 cycle after acceptance and the first rd_valid at the first rvalid.
- Counters are log2(LINE_WORDS)+1 bits wide and never wrap within a transaction.
- Extra R beats beyond the burst are impossible per AXI; a stray rlast triggers only the error flag and has no effect on state.

Test Plan:
- Refill, req_addr=0x8000_001C, all ready high, rdata = 0..7 → araddr=0x8000_0000, arlen=7, arsize=2, arburst=1; 8 rd_valid beats with rd_last on value 7; done with err=0.
- Writeback, addr=0x0000_0044, wd_data 0xA0..0xA7 → awaddr=0x0000_0040, awlen=7; 8 W beats in order, wlast on 0xA7, wstrb=F; done after bvalid, err=0.
- Writeback with awready delayed 20 cycles while W completes first → W completes first; bready waits for AW; exactly one done.
- wready and wd_valid toggled randomly → no dropped or duplicated words; wlast on the 8th handshake only.
- Refill with rresp=2'b10 on beat 3 → all 8 beats still delivered; done with err=1. Writeback with bresp=2'b11 → err=1.
- Reset asserted mid-RD_DATA after beat 4 → all outputs 0 asynchronously; no done; a fresh refill afterwards completes normally.

Source files
------------

// File: rtl/axi_line_master.sv
// axi_line_master
// ---------------------------------------------------------------------------
// Turns single cache-line refill and writeback requests from the data cache
// into one AXI4 INCR burst on the dbus master port. The port feeds the
// SoC-side slave of the SoC-to-SDRAM clock-domain crossing. Only one
// transaction, read or write, is in flight at any time.
//
// Ports
//   clk, rst                  core clock, asynchronous active-high reset
//   req_valid/req_ready       line request handshake (ready only when idle)
//   req_write                 1 = writeback, 0 = refill
//   req_addr                  any byte address inside the target line
//   wd_valid/wd_ready/wd_data writeback words, ascending address order
//   rd_valid/rd_data/rd_last  refill words, no backpressure
//   done/err                  one-cycle completion pulse, err qualifies done
//   m_axi_aw*/w*/b*           AXI4 write address, data and response channels
//   m_axi_ar*/r*              AXI4 read address and data channels
// ---------------------------------------------------------------------------
module axi_line_master #(
    parameter int LINE_WORDS = 8,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,

    input  logic                  wd_valid,
    output logic                  wd_ready,
    input  logic [31:0]           wd_data,

    output logic                  rd_valid,
    output logic [31:0]           rd_data,
    output logic                  rd_last,

    output logic                  done,
    output logic                  err,

    output logic [ADDR_WIDTH-1:0] m_axi_awaddr,
    output logic [7:0]            m_axi_awlen,
    output logic [2:0]            m_axi_awsize,
    output logic [1:0]            m_axi_awburst,
    output logic                  m_axi_awvalid,
    input  logic                  m_axi_awready,

    output logic [31:0]           m_axi_wdata,
    output logic [3:0]            m_axi_wstrb,
    output logic                  m_axi_wlast,
    output logic                  m_axi_wvalid,
    input  logic                  m_axi_wready,

    input  logic [1:0]            m_axi_bresp,
    input  logic                  m_axi_bvalid,
    output logic                  m_axi_bready,

    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,

    input  logic [31:0]           m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
);

    // One extra counter bit so the write counter can hold LINE_WORDS itself,
    // which marks "all words sent" without wrapping back to zero.
    localparam int CW          = $clog2(LINE_WORDS) + 1;
    localparam int OFFSET_BITS = $clog2(LINE_WORDS * 4);

    localparam logic [CW-1:0]         LAST_BEAT = CW'(LINE_WORDS - 1);
    localparam logic [CW-1:0]         LINE_CNT  = CW'(LINE_WORDS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << OFFSET_BITS;

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR,
        WR_RESP,
        DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   addr_q,  addr_d;
    logic [CW-1:0]           cnt_q,   cnt_d;
    logic                    aw_done_q, aw_done_d;
    logic                    err_acc_q, err_acc_d;
    logic                    w_room;

    // Burst shape never changes: a whole line of 32-bit words, incrementing.
    assign m_axi_awaddr  = addr_q;
    assign m_axi_awlen   = 8'(LINE_WORDS - 1);
    assign m_axi_awsize  = 3'b010;
    assign m_axi_awburst = 2'b01;
    assign m_axi_wstrb   = 4'hF;

    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(LINE_WORDS - 1);
    assign m_axi_arsize  = 3'b010;
    assign m_axi_arburst = 2'b01;

    // Words still owed on the W channel of the current writeback.
    assign w_room = (cnt_q != LINE_CNT);

    // State, line address, beat counter, AW-accepted flag and error
    // accumulator. Reset abandons any burst in flight without a done pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            cnt_q     <= '0;
            aw_done_q <= 1'b0;
            err_acc_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            aw_done_q <= aw_done_d;
            err_acc_q <= err_acc_d;
        end
    end

    // Next-state and output decode. Every output defaults to its idle value
    // so each state only has to drive what it actively uses.
    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        aw_done_d     = aw_done_q;
        err_acc_d     = err_acc_q;

        req_ready     = 1'b0;
        wd_ready      = 1'b0;
        rd_valid      = 1'b0;
        rd_data       = '0;
        rd_last       = 1'b0;
        done          = 1'b0;
        err           = 1'b0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        m_axi_wdata   = '0;
        m_axi_wlast   = 1'b0;
        m_axi_bready  = 1'b0;
        m_axi_arvalid = 1'b0;
        m_axi_rready  = 1'b0;

        case (state_q)
            IDLE: begin
                // Gated by rst so the cache never sees a ready while the
                // block (and the CDC behind it) is still held in reset.
                req_ready = !rst;
                if (req_valid) begin
                    addr_d    = req_addr & ADDR_MASK;
                    cnt_d     = '0;
                    aw_done_d = 1'b0;
                    err_acc_d = 1'b0;
                    state_d   = req_write ? WR : RD_ADDR;
                end
            end

            RD_ADDR: begin
                m_axi_arvalid = 1'b1;
                if (m_axi_arready) begin
                    state_d = RD_DATA;
                end
            end

            RD_DATA: begin
                // Refill data is forwarded straight through; the cache
                // always sinks it, so rready never drops.
                m_axi_rready = 1'b1;
                rd_valid     = m_axi_rvalid;
                rd_data      = m_axi_rdata;
                rd_last      = m_axi_rvalid && (cnt_q == LAST_BEAT);
                if (m_axi_rvalid) begin
                    cnt_d = cnt_q + CW'(1);
                    // A slave rlast out of step with our own count is
                    // reported but never allowed to steer the state.
                    if ((m_axi_rresp != 2'b00) || (m_axi_rlast != (cnt_q == LAST_BEAT))) begin
                        err_acc_d = 1'b1;
                    end
                    if (cnt_q == LAST_BEAT) begin
                        state_d = DONE;
                    end
                end
            end

            WR: begin
                // AW and W progress independently; W may run ahead of,
                // alongside or behind the address handshake.
                m_axi_awvalid = !aw_done_q;
                m_axi_wvalid  = wd_valid && w_room;
                wd_ready      = m_axi_wready && w_room;
                m_axi_wdata   = wd_data;
                m_axi_wlast   = (cnt_q == LAST_BEAT);
                if (m_axi_awvalid && m_axi_awready) begin
                    aw_done_d = 1'b1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    cnt_d = cnt_q + CW'(1);
                end
                // Looking at the _d values lets AW and the final W beat
                // finish in the same cycle.
                if (aw_done_d && (cnt_d == LINE_CNT)) begin
                    state_d = WR_RESP;
                end
            end

            WR_RESP: begin
                m_axi_bready = 1'b1;
                if (m_axi_bvalid) begin
                    if (m_axi_bresp != 2'b00) begin
                        err_acc_d = 1'b1;
                    end
                    state_d = DONE;
                end
            end

            DONE: begin
                done      = 1'b1;
                err       = err_acc_q;
                cnt_d     = '0;
                aw_done_d = 1'b0;
                err_acc_d = 1'b0;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_line_master.sv
// tb_axi_line_master
// ---------------------------------------------------------------------------
// Self-checking bench for axi_line_master with LINE_WORDS = 8. A table of
// directed transactions and a batch of randomized ones are played through a
// small AXI slave model; the expected line address, data order, last-beat
// position and error flag come from plain arithmetic on each request.
// Hand-written sequences cover the reset state and reset during a refill.
// ---------------------------------------------------------------------------
module tb_axi_line_master;

    localparam int LINE_WORDS = 8;
    localparam int LINE_BYTES = LINE_WORDS * 4;
    localparam int BUDGET     = 2000;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic        wd_valid;
    logic        wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        err;
    logic [31:0] m_axi_awaddr;
    logic [7:0]  m_axi_awlen;
    logic [2:0]  m_axi_awsize;
    logic [1:0]  m_axi_awburst;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wlast;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [7:0]  m_axi_arlen;
    logic [2:0]  m_axi_arsize;
    logic [1:0]  m_axi_arburst;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata;
    logic [1:0]  m_axi_rresp;
    logic        m_axi_rlast;
    logic        m_axi_rvalid;
    logic        m_axi_rready;

    axi_line_master #(.LINE_WORDS(LINE_WORDS), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .err(err),
        .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
        .m_axi_wlast(m_axi_wlast), .m_axi_wvalid(m_axi_wvalid),
        .m_axi_wready(m_axi_wready),
        .m_axi_bresp(m_axi_bresp), .m_axi_bvalid(m_axi_bvalid),
        .m_axi_bready(m_axi_bready),
        .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid),
        .m_axi_rready(m_axi_rready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One transaction: stimulus knobs plus the values the bench expects.
    typedef struct {
        logic        wr;
        logic [31:0] addr;
        int          err_beat;
        logic [1:0]  err_resp;
        int          bad_rlast;
        logic [1:0]  bresp;
        int          aw_delay;
        logic        rnd;
        logic [31:0] data_base;
        logic [31:0] exp_addr;
        logic        exp_err;
    } vec_t;

    int num_checks = 0;
    int num_errors = 0;

    logic [31:0] obs_addr;
    logic [7:0]  obs_len;
    logic [2:0]  obs_size;
    logic [1:0]  obs_burst;
    logic [31:0] obs_data[$];
    int          obs_addr_hs;
    int          obs_last_cnt;
    int          obs_last_idx;
    int          obs_first_ar;
    int          obs_taken;
    int          obs_done_cnt;
    logic        obs_err;
    logic        obs_wstrb_bad;
    logic        obs_bready_early;
    logic        obs_timeout;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_checks++;
        if (act !== exp) begin
            num_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] addr, input int err_beat,
                                input logic [1:0] err_resp, input int bad_rlast,
                                input logic [1:0] bresp, input int aw_delay, input logic rnd,
                                input logic [31:0] data_base, input logic [31:0] exp_addr,
                                input logic exp_err);
        vec_t v;
        v.wr = wr; v.addr = addr; v.err_beat = err_beat; v.err_resp = err_resp;
        v.bad_rlast = bad_rlast; v.bresp = bresp; v.aw_delay = aw_delay; v.rnd = rnd;
        v.data_base = data_base; v.exp_addr = exp_addr; v.exp_err = exp_err;
        return v;
    endfunction

    task automatic idleInputs();
        req_valid = 0; req_write = 0; req_addr = '0;
        wd_valid = 0; wd_data = '0;
        m_axi_awready = 0; m_axi_wready = 0;
        m_axi_bresp = 0; m_axi_bvalid = 0;
        m_axi_arready = 0;
        m_axi_rdata = '0; m_axi_rresp = 0; m_axi_rlast = 0; m_axi_rvalid = 0;
    endtask

    function automatic logic [10:0] ctrlOutputs();
        return {req_ready, wd_ready, rd_valid, rd_last, done, err,
                m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid, m_axi_rready};
    endfunction

    // Issues the request, then plays the AXI slave and cache side cycle by
    // cycle (inputs at negedge, outputs sampled 1 ns later) until done has
    // been seen and three quiet cycles have followed.
    task automatic applyStimulus(input vec_t v);
        int   k = 0;
        int   post = -1;
        int   beats = 0;
        int   wbeats = 0;
        logic addr_seen = 0;
        logic b_done = 0;

        obs_data.delete();
        obs_addr = '0; obs_len = '0; obs_size = '0; obs_burst = '0;
        obs_addr_hs = 0; obs_last_cnt = 0; obs_last_idx = -1; obs_first_ar = -1;
        obs_taken = 0; obs_done_cnt = 0; obs_err = 0; obs_wstrb_bad = 0;
        obs_bready_early = 0; obs_timeout = 0;

        @(negedge clk);
        req_valid = 1; req_write = v.wr; req_addr = v.addr;
        #1;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 0;

        while (k < BUDGET && post < 3) begin
            if (!v.wr) begin
                m_axi_arready = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                if (addr_seen && beats < LINE_WORDS) begin
                    m_axi_rvalid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                    m_axi_rdata  = v.data_base + 32'(beats);
                    m_axi_rresp  = (beats == v.err_beat) ? v.err_resp : 2'b00;
                    m_axi_rlast  = (beats == LINE_WORDS - 1) ^ (beats == v.bad_rlast);
                end else begin
                    m_axi_rvalid = 0; m_axi_rlast = 0; m_axi_rresp = 0;
                end
            end else begin
                m_axi_awready = (k >= v.aw_delay) ? (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                m_axi_wready  = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                wd_valid      = (obs_taken < LINE_WORDS) ? (v.rnd ? 1'($urandom_range(0, 1)) : 1'b1) : 1'b0;
                wd_data       = v.data_base + 32'(obs_taken);
                m_axi_bvalid  = addr_seen && (wbeats == LINE_WORDS) && !b_done;
                m_axi_bresp   = v.bresp;
            end
            #1;
            if (!v.wr) begin
                if (m_axi_arvalid && obs_first_ar < 0) obs_first_ar = k;
                if (m_axi_arvalid && m_axi_arready) begin
                    obs_addr_hs++;
                    obs_addr = m_axi_araddr; obs_len = m_axi_arlen;
                    obs_size = m_axi_arsize; obs_burst = m_axi_arburst;
                    addr_seen = 1;
                end
                if (m_axi_rvalid && m_axi_rready) beats++;
                if (rd_valid) begin
                    obs_data.push_back(rd_data);
                    if (rd_last) begin
                        obs_last_cnt++;
                        obs_last_idx = obs_data.size() - 1;
                    end
                end
            end else begin
                if (m_axi_bready && !(addr_seen && wbeats == LINE_WORDS)) obs_bready_early = 1;
                if (m_axi_awvalid && m_axi_awready) begin
                    obs_addr_hs++;
                    obs_addr = m_axi_awaddr; obs_len = m_axi_awlen;
                    obs_size = m_axi_awsize; obs_burst = m_axi_awburst;
                    addr_seen = 1;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    obs_data.push_back(m_axi_wdata);
                    if (m_axi_wstrb != 4'hF) obs_wstrb_bad = 1;
                    if (m_axi_wlast) begin
                        obs_last_cnt++;
                        obs_last_idx = obs_data.size() - 1;
                    end
                    wbeats++;
                end
                if (wd_valid && wd_ready) obs_taken++;
                if (m_axi_bvalid && m_axi_bready) b_done = 1;
            end
            if (done) begin
                obs_done_cnt++;
                obs_err = err;
            end
            if (post >= 0) post++;
            else if (done) post = 0;
            k++;
            @(negedge clk);
        end
        if (post < 3) obs_timeout = 1;
        idleInputs();
    endtask

    task automatic checkOutput(input vec_t v, input string tag);
        int nbad = 0;
        for (int i = 0; i < obs_data.size(); i++) begin
            if (obs_data[i] !== v.data_base + 32'(i)) nbad++;
        end
        check({tag, ".completed"},   32'(obs_timeout), 32'd0);
        check({tag, ".addr"},        obs_addr, v.exp_addr);
        check({tag, ".addr_hs"},     32'(obs_addr_hs), 32'd1);
        check({tag, ".len"},         32'(obs_len), 32'(LINE_WORDS - 1));
        check({tag, ".size"},        32'(obs_size), 32'd2);
        check({tag, ".burst"},       32'(obs_burst), 32'd1);
        check({tag, ".beats"},       32'(obs_data.size()), 32'(LINE_WORDS));
        check({tag, ".data_bad"},    32'(nbad), 32'd0);
        check({tag, ".last_cnt"},    32'(obs_last_cnt), 32'd1);
        check({tag, ".last_idx"},    32'(obs_last_idx), 32'(LINE_WORDS - 1));
        check({tag, ".done_cnt"},    32'(obs_done_cnt), 32'd1);
        check({tag, ".err"},         32'(obs_err), 32'(v.exp_err));
        if (v.wr) begin
            check({tag, ".wstrb_bad"},    32'(obs_wstrb_bad), 32'd0);
            check({tag, ".words_taken"},  32'(obs_taken), 32'(LINE_WORDS));
            check({tag, ".bready_early"}, 32'(obs_bready_early), 32'd0);
        end else if (!v.rnd) begin
            check({tag, ".ar_latency"},   32'(obs_first_ar), 32'd0);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t tbl[8];
        vec_t v;
        int   rst_done;

        tbl[0] = mk(0, 32'h8000_001C, -1, 2'b00, -1, 2'b00,  0, 0, 32'h0000_0000, 32'h8000_0000, 0);
        tbl[1] = mk(1, 32'h0000_0044, -1, 2'b00, -1, 2'b00,  0, 0, 32'h0000_00A0, 32'h0000_0040, 0);
        tbl[2] = mk(1, 32'h1234_5678, -1, 2'b00, -1, 2'b00, 20, 0, 32'h0000_00A0, 32'h1234_5660, 0);
        tbl[3] = mk(1, 32'h0000_1000, -1, 2'b00, -1, 2'b00,  3, 1, 32'h0000_00A0, 32'h0000_1000, 0);
        tbl[4] = mk(0, 32'h4000_0004,  3, 2'b10, -1, 2'b00,  0, 0, 32'h0000_0100, 32'h4000_0000, 1);
        tbl[5] = mk(1, 32'hFFFF_FFFF, -1, 2'b00, -1, 2'b11,  0, 0, 32'h0000_00A0, 32'hFFFF_FFE0, 1);
        tbl[6] = mk(0, 32'h0000_003F, -1, 2'b00, -1, 2'b00,  0, 1, 32'h0000_0055, 32'h0000_0020, 0);
        tbl[7] = mk(0, 32'h0000_0200, -1, 2'b00,  2, 2'b00,  0, 0, 32'h0000_0007, 32'h0000_0200, 1);

        rst = 1;
        idleInputs();
        #3;
        check("reset_outputs", 32'(ctrlOutputs()), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        #1;
        check("req_ready_after_reset", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(tbl[i]);
            checkOutput(tbl[i], $sformatf("table%0d", i));
        end

        // Reset during a refill after beats 0..4 have been delivered.
        @(negedge clk);
        req_valid = 1; req_write = 0; req_addr = 32'h2000_0010; m_axi_arready = 1;
        @(negedge clk);
        req_valid = 0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            m_axi_rvalid = 1; m_axi_rdata = 32'(i); m_axi_rresp = 0; m_axi_rlast = 0;
            @(negedge clk);
        end
        m_axi_rvalid = 1; m_axi_rdata = 32'd5;
        #1;
        check("mid_burst_rd_valid", 32'(rd_valid), 32'd1);
        #2;
        rst = 1;
        #1;
        check("async_reset_outputs", 32'(ctrlOutputs()), 32'd0);
        rst_done = 0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            #1;
            if (done) rst_done++;
        end
        check("no_done_on_reset", 32'(rst_done), 32'd0);
        idleInputs();
        rst = 0;
        #1;
        check("req_ready_after_mid_reset", 32'(req_ready), 32'd1);
        v = mk(0, 32'h2000_0010, -1, 2'b00, -1, 2'b00, 0, 0, 32'h0000_0300, 32'h2000_0000, 0);
        applyStimulus(v);
        checkOutput(v, "post_reset_refill");

        // Randomized transactions; expectations come from the request alone.
        for (int n = 0; n < 24; n++) begin
            v.wr        = 1'($urandom_range(0, 1));
            v.addr      = $urandom;
            v.err_beat  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LINE_WORDS - 1)) : -1;
            v.err_resp  = 2'($urandom_range(1, 3));
            v.bad_rlast = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, LINE_WORDS - 2)) : -1;
            v.bresp     = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            v.aw_delay  = int'($urandom_range(0, 12));
            v.rnd       = 1;
            v.data_base = $urandom;
            v.exp_addr  = v.addr - (v.addr % LINE_BYTES);
            v.exp_err   = v.wr ? (v.bresp != 2'b00) : ((v.err_beat >= 0) || (v.bad_rlast >= 0));
            applyStimulus(v);
            checkOutput(v, $sformatf("random%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
